// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the core execute stage and a
// request/ready data bus. The core is stalled while an access is in flight.
// The unit steers byte lanes for stores, sign/zero-extends loads, rejects
// misaligned accesses and illegal size codes, and aborts a bus access that
// sees no mem_ready within TIMEOUT cycles.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   core_req/we/size/addr/wd  access request from the execute stage
//   core_rd, core_err         load result and status, valid in DONE
//   core_stall                hold PC and inputs while high (combinational)
//   mem_req/we/be/addr/wd     registered bus request, stable during BUS
//   mem_rdata, mem_ready      bus read data and one-cycle completion pulse
module riscv_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [2:0]            core_size,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [31:0]           core_wd,
    output logic [31:0]           core_rd,
    output logic                  core_stall,
    output logic [1:0]            core_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wd,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;
    localparam logic [1:0] ERR_SIZE  = 2'b11;

    // Counter only has to reach TIMEOUT-1; the compare is gated off when
    // TIMEOUT is 0, so the cast of -1 in that case is never used.
    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [3:0]              mem_be_q, mem_be_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]             mem_wd_q, mem_wd_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              off_q, off_d;
    logic [31:0]             rd_q, rd_d;
    logic [1:0]              err_q, err_d;

    // Request decode from the live core inputs (used only in IDLE).
    logic        bad_size, misaligned;
    logic [3:0]  req_be;
    logic [31:0] req_wd;

    always_comb begin
        bad_size   = (core_size == 3'b011) || (core_size == 3'b110) ||
                     (core_size == 3'b111);
        misaligned = ((core_size[1:0] == 2'b01) && core_addr[0]) ||
                     ((core_size[1:0] == 2'b10) && (core_addr[1:0] != 2'b00));
        case (core_size[1:0])
            2'b00:   begin req_be = 4'b0001 << core_addr[1:0]; req_wd = {4{core_wd[7:0]}};  end
            2'b01:   begin req_be = 4'b0011 << core_addr[1:0]; req_wd = {2{core_wd[15:0]}}; end
            default: begin req_be = 4'b1111;                   req_wd = core_wd;            end
        endcase
    end

    // Load extraction from the latched offset/size; size_q[2] marks unsigned.
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;

    always_comb begin
        rd_byte = mem_rdata[{off_q, 3'b000} +: 8];
        rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q[1:0])
            2'b00:   load_data = {{24{~size_q[2] & rd_byte[7]}}, rd_byte};
            2'b01:   load_data = {{16{~size_q[2] & rd_half[15]}}, rd_half};
            default: load_data = mem_rdata;
        endcase
        if (mem_we_q) load_data = 32'h0;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_we_d   = mem_we_q;
        mem_be_d   = mem_be_q;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        size_d     = size_q;
        off_d      = off_q;
        rd_d       = rd_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (core_req) begin
                    if (bad_size) begin
                        err_d   = ERR_SIZE;
                        rd_d    = 32'h0;
                        state_d = S_DONE;
                    end else if (misaligned) begin
                        err_d   = ERR_ALIGN;
                        rd_d    = 32'h0;
                        state_d = S_DONE;
                    end else begin
                        mem_we_d   = core_we;
                        mem_be_d   = req_be;
                        mem_addr_d = {core_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wd_d   = req_wd;
                        size_d     = core_size;
                        off_d      = core_addr[1:0];
                        cnt_d      = '0;
                        state_d    = S_BUS;
                    end
                end
            end
            S_BUS: begin
                cnt_d = cnt_q + 1'b1;
                // Ready is checked first so it wins over a coincident timeout.
                if (mem_ready) begin
                    rd_d    = load_data;
                    err_d   = ERR_OK;
                    state_d = S_DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    rd_d    = 32'h0;
                    err_d   = ERR_TMO;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        mem_req_d = (state_d == S_BUS);
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_be_q   <= 4'b0000;
            mem_addr_q <= '0;
            mem_wd_q   <= 32'h0;
            size_q     <= 3'b000;
            off_q      <= 2'b00;
            rd_q       <= 32'h0;
            err_q      <= ERR_OK;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_be_q   <= mem_be_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            size_q     <= size_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
            err_q      <= err_d;
        end
    end

    assign core_stall = core_req & (state_q != S_DONE);
    assign core_rd    = rd_q;
    assign core_err   = err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_be     = mem_be_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wd     = mem_wd_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed tests for riscv_lsu (TIMEOUT=4). Each task drives one
// scenario and compares DUT outputs against hand-computed values.
module tb_riscv_lsu;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req, core_we;
    logic [2:0]    core_size;
    logic [AW-1:0] core_addr;
    logic [31:0]   core_wd, core_rd;
    logic          core_stall;
    logic [1:0]    core_err;
    logic          mem_req, mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wd, mem_rdata;
    logic          mem_ready;

    int passed = 0;
    int total  = 0;

    // Observations from the most recent access.
    int          o_stalls, o_bus;
    logic [3:0]  o_be;
    logic [31:0] o_addr, o_wd, o_rd;
    logic        o_we, o_req_done, o_unstable;
    logic [1:0]  o_err;

    riscv_lsu #(.ADDR_WIDTH(AW), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_size(core_size),
        .core_addr(core_addr), .core_wd(core_wd),
        .core_rd(core_rd), .core_stall(core_stall), .core_err(core_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // Runs one access. wait_n = number of BUS cycles before the ready cycle
    // (-1 = never ready). With scramble set, core address/data are changed
    // after the first BUS cycle to show the bus side is latched.
    task automatic access(input logic we, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int wait_n, input logic [31:0] rdata,
                          input logic scramble);
        logic done = 1'b0;
        core_req = 1'b1; core_we = we; core_size = size;
        core_addr = addr; core_wd = wd; mem_rdata = rdata; mem_ready = 1'b0;
        o_stalls = 0; o_bus = 0; o_unstable = 1'b0;
        o_be = 'x; o_addr = 'x; o_wd = 'x; o_we = 1'bx;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!core_stall) begin done = 1'b1; break; end
            o_stalls++;
            if (mem_req) begin
                o_bus++;
                if (o_bus == 1) begin
                    o_be = mem_be; o_addr = mem_addr; o_wd = mem_wd; o_we = mem_we;
                end else if (mem_be !== o_be || mem_addr !== o_addr ||
                             mem_wd !== o_wd || mem_we !== o_we) begin
                    o_unstable = 1'b1;
                end
                if (scramble) begin core_addr = ~addr; core_wd = ~wd; end
            end
            mem_ready = mem_req && (wait_n >= 0) && (o_bus == wait_n + 1);
            @(negedge clk);
        end
        total++;
        if (!done) $display("FAIL access_done: no DONE within budget (size %b addr %h)", size, addr);
        else passed++;
        o_rd = core_rd; o_err = core_err; o_req_done = mem_req;
        core_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_size = 3'b010;
        core_addr = '0; core_wd = '0; mem_rdata = '0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (mem_req !== 1'b0)   $display("FAIL rst_mem_req got %b want 0", mem_req); else passed++;
        total++; if (mem_we !== 1'b0)    $display("FAIL rst_mem_we got %b want 0", mem_we); else passed++;
        total++; if (mem_be !== 4'b0000) $display("FAIL rst_mem_be got %b want 0000", mem_be); else passed++;
        total++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr got %h want 0", mem_addr); else passed++;
        total++; if (mem_wd !== 32'h0)   $display("FAIL rst_mem_wd got %h want 0", mem_wd); else passed++;
        total++; if (core_rd !== 32'h0)  $display("FAIL rst_core_rd got %h want 0", core_rd); else passed++;
        total++; if (core_err !== 2'b00) $display("FAIL rst_core_err got %b want 00", core_err); else passed++;
        total++; if (core_stall !== 1'b0) $display("FAIL rst_stall got %b want 0", core_stall); else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store_word;
        access(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 32'h0, 1'b0);
        total++; if (o_addr !== 32'h104)      $display("FAIL sw_addr got %h want 00000104", o_addr); else passed++;
        total++; if (o_be !== 4'b1111)        $display("FAIL sw_be got %b want 1111", o_be); else passed++;
        total++; if (o_wd !== 32'hDEADBEEF)   $display("FAIL sw_wd got %h want deadbeef", o_wd); else passed++;
        total++; if (o_we !== 1'b1)           $display("FAIL sw_we got %b want 1", o_we); else passed++;
        total++; if (o_stalls != 2)           $display("FAIL sw_stalls got %0d want 2", o_stalls); else passed++;
        total++; if (o_err !== 2'b00)         $display("FAIL sw_err got %b want 00", o_err); else passed++;
        total++; if (o_rd !== 32'h0)          $display("FAIL sw_rd got %h want 0", o_rd); else passed++;
        total++; if (o_req_done !== 1'b0)     $display("FAIL sw_req_in_done got %b want 0", o_req_done); else passed++;
    endtask

    task automatic test_load_byte;
        access(1'b0, 3'b000, 32'h203, 32'h0, 0, 32'h80FFFFFF, 1'b0);
        total++; if (o_be !== 4'b1000)      $display("FAIL lb_be got %b want 1000", o_be); else passed++;
        total++; if (o_addr !== 32'h200)    $display("FAIL lb_addr got %h want 00000200", o_addr); else passed++;
        total++; if (o_rd !== 32'hFFFFFF80) $display("FAIL lb_rd got %h want ffffff80", o_rd); else passed++;
        total++; if (o_err !== 2'b00)       $display("FAIL lb_err got %b want 00", o_err); else passed++;
        access(1'b0, 3'b100, 32'h203, 32'h0, 0, 32'h80FFFFFF, 1'b0);
        total++; if (o_rd !== 32'h00000080) $display("FAIL lbu_rd got %h want 00000080", o_rd); else passed++;
    endtask

    task automatic test_store_half_wait;
        access(1'b1, 3'b001, 32'h12, 32'h0000ABCD, 3, 32'h0, 1'b1);
        total++; if (o_be !== 4'b1100)      $display("FAIL sh_be got %b want 1100", o_be); else passed++;
        total++; if (o_addr !== 32'h10)     $display("FAIL sh_addr got %h want 00000010", o_addr); else passed++;
        total++; if (o_wd !== 32'hABCDABCD) $display("FAIL sh_wd got %h want abcdabcd", o_wd); else passed++;
        total++; if (o_stalls != 5)         $display("FAIL sh_stalls got %0d want 5", o_stalls); else passed++;
        total++; if (o_unstable !== 1'b0)   $display("FAIL sh_bus_stable got %b want 0", o_unstable); else passed++;
    endtask

    task automatic test_errors;
        access(1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h0, 1'b0);
        total++; if (o_err !== 2'b01) $display("FAIL lw_misal_err got %b want 01", o_err); else passed++;
        total++; if (o_stalls != 1)   $display("FAIL lw_misal_stalls got %0d want 1", o_stalls); else passed++;
        total++; if (o_bus != 0)      $display("FAIL lw_misal_bus got %0d want 0", o_bus); else passed++;
        access(1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 1'b0);
        total++; if (o_err !== 2'b11) $display("FAIL bad_size_err got %b want 11", o_err); else passed++;
        total++; if (o_bus != 0)      $display("FAIL bad_size_bus got %0d want 0", o_bus); else passed++;
    endtask

    task automatic test_timeout;
        access(1'b0, 3'b010, 32'h300, 32'h0, -1, 32'h12345678, 1'b0);
        total++; if (o_err !== 2'b10) $display("FAIL tmo_err got %b want 10", o_err); else passed++;
        total++; if (o_rd !== 32'h0)  $display("FAIL tmo_rd got %h want 0", o_rd); else passed++;
        total++; if (o_stalls != 5)   $display("FAIL tmo_stalls got %0d want 5", o_stalls); else passed++;
        total++; if (o_bus != 4)      $display("FAIL tmo_bus got %0d want 4", o_bus); else passed++;
        access(1'b0, 3'b010, 32'h300, 32'h0, 3, 32'h12345678, 1'b0);
        total++; if (o_err !== 2'b00)       $display("FAIL tmo_ready_err got %b want 00", o_err); else passed++;
        total++; if (o_rd !== 32'h12345678) $display("FAIL tmo_ready_rd got %h want 12345678", o_rd); else passed++;
    endtask

    task automatic test_reset_in_bus;
        core_req = 1'b1; core_we = 1'b0; core_size = 3'b010;
        core_addr = 32'h40; core_wd = 32'h0; mem_ready = 1'b0;
        @(negedge clk);             // cycle 1: first BUS cycle
        @(negedge clk);             // cycle 2: second BUS cycle
        total++; if (mem_req !== 1'b1) $display("FAIL rbus_req_before got %b want 1", mem_req); else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++; if (mem_req !== 1'b0)   $display("FAIL rbus_mem_req got %b want 0", mem_req); else passed++;
        total++; if (mem_be !== 4'b0000) $display("FAIL rbus_mem_be got %b want 0000", mem_be); else passed++;
        total++; if (mem_addr !== 32'h0) $display("FAIL rbus_mem_addr got %h want 0", mem_addr); else passed++;
        total++; if (core_err !== 2'b00) $display("FAIL rbus_core_err got %b want 00", core_err); else passed++;
        rst = 1'b0; core_req = 1'b0;
        @(negedge clk);
        // An IDLE unit accepts a fresh access with the minimal latency.
        access(1'b0, 3'b001, 32'h2, 32'h0, 0, 32'h80010000, 1'b0);
        total++; if (o_stalls != 2)         $display("FAIL rbus_next_stalls got %0d want 2", o_stalls); else passed++;
        total++; if (o_rd !== 32'hFFFF8001) $display("FAIL lh_rd got %h want ffff8001", o_rd); else passed++;
    endtask

    task automatic test_back_to_back;
        access(1'b0, 3'b101, 32'h2, 32'h0, 0, 32'h80010000, 1'b0);
        total++; if (o_rd !== 32'h00008001) $display("FAIL lhu_rd got %h want 00008001", o_rd); else passed++;
        total++; if (o_be !== 4'b1100)      $display("FAIL lhu_be got %b want 1100", o_be); else passed++;
        access(1'b1, 3'b000, 32'h7, 32'h000000A5, 1, 32'h0, 1'b0);
        total++; if (o_be !== 4'b1000)      $display("FAIL sb_be got %b want 1000", o_be); else passed++;
        total++; if (o_wd !== 32'hA5A5A5A5) $display("FAIL sb_wd got %h want a5a5a5a5", o_wd); else passed++;
        total++; if (o_stalls != 3)         $display("FAIL sb_stalls got %0d want 3", o_stalls); else passed++;
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_store_half_wait();
        test_errors();
        test_timeout();
        test_reset_in_bus();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
